// File: rtl/rr_mux_arbiter_if.sv
// Request/data/grant bundle between the 7 requesters and the round-robin
// mux arbiter.
interface rr_mux_arbiter_if;
  logic [6:0] req;
  logic [6:0] data;
  logic [6:0] grant;
  logic [2:0] mux_select;
  logic       out;
  logic       busy;

  modport master (
    output req, data,
    input  grant, mux_select, out, busy
  );

  modport slave (
    input  req, data,
    output grant, mux_select, out, busy
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin 7:1 mux arbiter with registered one-hot grant and binary select.
// Optional owner hold limit enabled with macro HOLD_TIMEOUT_EN (uses MAX_HOLD).
//
// state | meaning
// IDLE  | no owner, grant = 0, mux_select = 3'b111
// OWNED | exactly one owner, mux_select = owner index
module rr_mux_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input logic           clock,
  input logic           reset,
  rr_mux_arbiter_if.slave bus
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] ptr_q, ptr_d;
  logic [6:0] grant_q, grant_d;
  logic       busy_q;
  logic [6:0] others;
  logic [2:0] win;
  logic [7:0] req_ext, data_ext;
  logic       owner_req;
  logic       new_grant;
  logic       timeout;

  if (MAX_HOLD < 2 || MAX_HOLD > 15) begin : g_bad_max_hold
    $error("rr_mux_arbiter: MAX_HOLD must be in 2..15");
  end

  // First set bit scanning from p+1 upward with wrap 6->0; 3'd7 when none.
  function automatic logic [2:0] rr_pick(input logic [6:0] r, input logic [2:0] p);
    logic [2:0] pick;
    logic [2:0] i3;
    int         idx;
    pick = 3'd7;
    for (int k = 7; k >= 1; k--) begin
      idx = int'(p) + k;
      if (idx >= 7) idx = idx - 7;
      i3 = 3'(idx);
      if (r[i3]) pick = i3;
    end
    return pick;
  endfunction

  assign req_ext   = {1'b0, bus.req};
  assign data_ext  = {1'b0, bus.data};
  assign owner_req = req_ext[sel_q];
  assign others    = bus.req & ~grant_q;
  assign win       = rr_pick(others, ptr_q);

`ifdef HOLD_TIMEOUT_EN
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
  logic [3:0] cnt_q, cnt_d;

  assign timeout = (state_q == OWNED) && (cnt_q == HOLD_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (new_grant)
      cnt_d = 4'd0;
    else if (state_q == OWNED && cnt_q != HOLD_LAST)
      cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    new_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (win != 3'd7) new_grant = 1'b1;
      end
      OWNED: begin
        if ((!owner_req || timeout) && win != 3'd7) begin
          new_grant = 1'b1;
        end else if (!owner_req) begin
          state_d = IDLE;
          sel_d   = 3'd7;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 3'd7;
      end
    endcase
    if (new_grant) begin
      state_d = OWNED;
      sel_d   = win;
      ptr_d   = win;
    end
    grant_d = (sel_d == 3'd7) ? 7'd0 : 7'(8'd1 << sel_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 3'd7;
      ptr_q   <= 3'd6;
      grant_q <= 7'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      busy_q  <= (sel_d != 3'd7);
    end
  end

  assign bus.grant      = grant_q;
  assign bus.mux_select = sel_q;
  assign bus.busy       = busy_q;
  assign bus.out        = data_ext[sel_q];

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: directed scenarios plus random traffic,
// checked against a cycle-level owner/pointer reference model.
module tb_rr_mux_arbiter;
  localparam int MAX_HOLD = 8;
`ifdef HOLD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rr_mux_arbiter_if bus();

  rr_mux_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [6:0] grant;
    logic [2:0] sel;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: owner index (-1 = idle), last-granted pointer, hold count.
  int m_own = -1;
  int m_ptr = 6;
  int m_cnt = 0;
  int m_age = 0;

  function automatic int scan(input logic [6:0] r, input int p, input int excl);
    for (int k = 1; k <= 7; k++) begin
      int i;
      i = (p + k) % 7;
      if (i != excl && r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input logic rst, input logic [6:0] r);
    int  w;
    bit  rel, to;
    if (rst) begin
      m_own = -1; m_ptr = 6; m_cnt = 0; m_age = 0;
    end else if (m_own < 0) begin
      w = scan(r, m_ptr, -1);
      if (w >= 0) begin m_own = w; m_ptr = w; m_cnt = 0; m_age = 0; end
    end else begin
      rel = !r[m_own];
      to  = TO_EN && (m_cnt == MAX_HOLD - 1);
      w   = scan(r, m_ptr, m_own);
      if ((rel || to) && w >= 0) begin
        m_own = w; m_ptr = w; m_cnt = 0; m_age = 0;
      end else if (rel) begin
        m_own = -1;
      end else begin
        if (m_cnt < MAX_HOLD - 1) m_cnt++;
        m_age++;
      end
    end
  endtask

  task automatic step(input logic rst, input logic [6:0] q, input logic [6:0] d);
    exp_t e;
    reset    = rst;
    bus.req  = q;
    bus.data = d;
    model_step(rst, q);
    e.grant = (m_own < 0) ? 7'd0 : 7'(1 << m_own);
    e.sel   = (m_own < 0) ? 3'd7 : 3'(m_own);
    e.busy  = (m_own >= 0);
    @(posedge clock);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per clock edge, compared mid-cycle.
  initial begin
    exp_t e;
    logic exp_out;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        exp_out = (e.sel == 3'd7) ? 1'b0 : bus.data[e.sel];
        chk("grant", 32'(bus.grant), 32'(e.grant));
        chk("mux_select", 32'(bus.mux_select), 32'(e.sel));
        chk("busy", 32'(bus.busy), 32'(e.busy));
        chk("out", 32'(bus.out), 32'(exp_out));
      end
    end
  end

  initial begin
    logic [6:0] q, dropped, rq;
    reset    = 1'b1;
    bus.req  = 7'd0;
    bus.data = 7'd0;

    // Reset, single requester 0, data toggling while owned, then release.
    step(1, 7'd0, 7'd0);
    step(1, 7'd0, 7'd0);
    step(0, 7'b0000001, 7'd0);
    step(0, 7'b0000001, 7'd1);
    step(0, 7'b0000001, 7'd0);
    step(0, 7'b0000001, 7'd1);
    step(0, 7'd0, 7'd1);
    step(0, 7'd0, 7'd0);

    // All request; each owner drops two cycles after its grant.
    step(1, 7'd0, 7'd0);
    dropped = 7'd0;
    for (int n = 0; n < 18; n++) begin
      q = 7'h7f & ~dropped;
      if (m_own >= 0 && m_age >= 1) begin
        q[m_own] = 1'b0;
        dropped[m_own] = 1'b1;
      end
      step(0, q, 7'($urandom));
    end

    // Owner 6 releases with 0 and 5 pending: wrap to 0.
    step(1, 7'd0, 7'd0);
    step(0, 7'b1000000, 7'h40);
    step(0, 7'b1000000, 7'h00);
    step(0, 7'b0100001, 7'h01);
    step(0, 7'b0100001, 7'h00);

    // Owner 3 drops with no other request: back to idle.
    step(1, 7'd0, 7'd0);
    step(0, 7'b0001000, 7'h08);
    step(0, 7'b0001000, 7'h08);
    step(0, 7'd0, 7'h08);
    step(0, 7'd0, 7'h7f);

    // Reset mid-ownership of 4, then rearbitrate.
    step(0, 7'b0010000, 7'h10);
    step(0, 7'b0010000, 7'h10);
    step(1, 7'b0010000, 7'h10);
    step(0, 7'b0010000, 7'h10);
    step(0, 7'b0010000, 7'h00);

    // 2 and 5 held continuously: hold limit alternates owners when enabled.
    step(1, 7'd0, 7'd0);
    for (int n = 0; n < 40; n++) step(0, 7'b0100100, 7'($urandom));
    step(0, 7'd0, 7'd0);

    // Random traffic with sticky requests and occasional reset.
    rq = 7'd0;
    for (int n = 0; n < 400; n++) begin
      rq = rq ^ (7'($urandom) & 7'($urandom));
      step(($urandom_range(0, 39) == 0), rq, 7'($urandom));
    end
    step(0, 7'd0, 7'd0);

    repeat (2) @(negedge clock);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
